// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multiply/divide controller for the E stage.
//
// Accepts decoded HI/LO-class operations. Multiply and divide results are
// computed at the accept edge and held in a pending register. A latency
// counter then models the multi-cycle unit, and the HI/LO registers are
// written when the counter expires. While an operation is in flight, any
// further HI/LO operation in E is stalled.
//
// Optional feature: define MDU_MADD_EN to decode MADD/MADDU (codes 9/10).
// These accumulate into {HI,LO} with MUL_LAT latency. When the macro is
// undefined, codes 9/10 behave as NONE.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   md_op      E-stage operation code (0 NONE .. 10 MADDU)
//   md_a       rs operand (dividend / multiplicand / MTHI-MTLO source)
//   md_b       rt operand (divisor / multiplier)
//   flush      E-stage instruction killed this cycle; nothing is accepted
//   busy       multi-cycle operation in flight (state != IDLE)
//   stall      E-stage HI/LO operation must hold (valid & busy)
//   rd_data    HI for MFHI, LO for MFLO, otherwise 0
//   hi, lo     architectural HI/LO registers
//   dbg_state  current FSM state (0 IDLE, 1 MUL, 2 DIV)
//
// Handshake: an operation in md_op is accepted at a rising edge only when it
// is a valid code, busy is low and flush is low. When stall is high, the
// E stage must present the same operation again on the next cycle.
module mdu_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
`endif

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  // The counter only needs to hold LAT-1.
  localparam int CW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [63:0]   pend;

  logic        is_mul, is_div, valid, accept;
  logic [63:0] a_sx, b_sx, prod_s, prod_u, mul_res, div_res;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;

  // Decode
  always_comb begin
    is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
`ifdef MDU_MADD_EN
    is_mul = is_mul || (md_op == OP_MADD) || (md_op == OP_MADDU);
`endif
    is_div = (md_op == OP_DIV) || (md_op == OP_DIVU);
    valid  = is_mul || is_div || (md_op == OP_MTHI) || (md_op == OP_MTLO) ||
             (md_op == OP_MFHI) || (md_op == OP_MFLO);
  end

  assign busy      = (state != S_IDLE);
  assign stall     = valid && busy;
  assign accept    = valid && !busy && !flush;
  assign dbg_state = state;
  assign rd_data   = (md_op == OP_MFHI) ? hi :
                     (md_op == OP_MFLO) ? lo : 32'd0;

  // Multiply. The low 64 bits of a product of sign-extended operands equal
  // the signed 32x32 product, so one unsigned multiplier form serves both.
  assign a_sx   = {{32{md_a[31]}}, md_a};
  assign b_sx   = {{32{md_b[31]}}, md_b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, md_a} * {32'd0, md_b};

  always_comb begin
    mul_res = prod_s;
    case (md_op)
      OP_MULTU: mul_res = prod_u;
`ifdef MDU_MADD_EN
      OP_MADD:  mul_res = {hi, lo} + prod_s;
      OP_MADDU: mul_res = {hi, lo} + prod_u;
`endif
      default:  mul_res = prod_s;
    endcase
  end

  // Signed divide works on magnitudes. 0x80000000 keeps its bit pattern when
  // negated, which, read as unsigned, is the correct magnitude. The overflow
  // case 0x80000000 / -1 therefore yields 0x80000000 rem 0 without special
  // handling.
  assign a_mag = md_a[31] ? -md_a : md_a;
  assign b_mag = md_b[31] ? -md_b : md_b;
  assign q_mag = (md_b == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign r_mag = (md_b == 32'd0) ? 32'd0 : a_mag % b_mag;
  assign q_s   = (md_a[31] ^ md_b[31]) ? -q_mag : q_mag;
  assign r_s   = md_a[31] ? -r_mag : r_mag;
  assign q_u   = (md_b == 32'd0) ? 32'd0 : md_a / md_b;
  assign r_u   = (md_b == 32'd0) ? 32'd0 : md_a % md_b;

  always_comb begin
    if (md_b == 32'd0)       div_res = {md_a, 32'hFFFF_FFFF};
    else if (md_op == OP_DIV) div_res = {r_s, q_s};
    else                      div_res = {r_u, q_u};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      pend  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              pend  <= mul_res;
              cnt   <= CW'(MUL_LAT - 1);
              state <= S_MUL;
            end else if (is_div) begin
              pend  <= div_res;
              cnt   <= CW'(DIV_LAT - 1);
              state <= S_DIV;
            end else if (md_op == OP_MTHI) begin
              hi <= md_a;
            end else if (md_op == OP_MTLO) begin
              lo <= md_a;
            end
          end
        end
        S_MUL, S_DIV: begin
          // flush is ignored here: the owning instruction has already left E.
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            {hi, lo} <= pend;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Testbench for mdu_ctrl: directed and randomized operations, checked against
// an arithmetic reference model of HI/LO and of the operation latencies.
module tb_mdu_ctrl;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] md_a, md_b;
  logic        flush;
  logic        busy, stall;
  logic [31:0] rd_data, hi, lo;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference architectural state and expected-result queue.
  logic [31:0] m_hi, m_lo;
  logic [31:0] exp_q[$];

  mdu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .md_a(md_a), .md_b(md_b),
    .flush(flush), .busy(busy), .stall(stall), .rd_data(rd_data),
    .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference model
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint          sa, sb, ps;
    longint unsigned ua, ub, pu;
    if (sgn) begin
      sa = $signed(a); sb = $signed(b); ps = sa * sb;
      return ps;
    end
    ua = a; ub = b; pu = ua * ub;
    return pu;
  endfunction

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end else begin
      q = longint'({32'd0, a}) / longint'({32'd0, b});
      r = longint'({32'd0, a}) % longint'({32'd0, b});
    end
    return {r[31:0], q[31:0]};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a multi-cycle op, hammer the busy window with random ops, then
  // check completion in the first free cycle (left presenting MFHI).
  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] res;
    int          lat;
    logic [31:0] e_hi, e_lo;
    case (op)
      4'd1:    res = ref_mul(a, b, 1'b1);
      4'd2:    res = ref_mul(a, b, 1'b0);
      4'd3:    res = ref_div(a, b, 1'b1);
      4'd4:    res = ref_div(a, b, 1'b0);
      4'd9:    res = {m_hi, m_lo} + ref_mul(a, b, 1'b1);
      default: res = {m_hi, m_lo} + ref_mul(a, b, 1'b0);
    endcase
    lat = (op == 4'd3 || op == 4'd4) ? DIV_LAT : MUL_LAT;
    md_op = op; md_a = a; md_b = b; flush = 1'b0;
    #1;
    check("start_busy", 32'(busy), 32'd0);
    check("start_stall", 32'(stall), 32'd0);
    exp_q.push_back(res[63:32]);
    exp_q.push_back(res[31:0]);
    tick();
    for (int k = 1; k <= lat; k++) begin
      md_op = 4'($urandom_range(1, 8));
      md_a  = $urandom;
      md_b  = $urandom;
      flush = 1'($urandom_range(0, 1));
      #1;
      check("inflight_busy", 32'(busy), 32'd1);
      check("inflight_stall", 32'(stall), 32'd1);
      check("inflight_hi_held", hi, m_hi);
      tick();
    end
    md_op = 4'd7; flush = 1'b0;
    #1;
    e_hi = exp_q.pop_front();
    e_lo = exp_q.pop_front();
    check("done_busy", 32'(busy), 32'd0);
    check("done_stall", 32'(stall), 32'd0);
    check("done_mfhi", rd_data, e_hi);
    check("done_hi", hi, e_hi);
    check("done_lo", lo, e_lo);
    m_hi = e_hi;
    m_lo = e_lo;
  endtask

  // MTHI/MTLO with optional flush, then read back with MFHI/MFLO.
  task automatic mt_op(input logic [3:0] op, input logic [31:0] a, input bit fl);
    md_op = op; md_a = a; md_b = $urandom; flush = fl;
    #1;
    check("mt_stall", 32'(stall), 32'd0);
    tick();
    if (!fl) begin
      if (op == 4'd5) m_hi = a; else m_lo = a;
    end
    md_op = (op == 4'd5) ? 4'd7 : 4'd8; flush = 1'b0;
    #1;
    check("mf_stall", 32'(stall), 32'd0);
    check("mf_rd", rd_data, (op == 4'd5) ? m_hi : m_lo);
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
  endtask

  // A start presented together with flush must be dropped.
  task automatic flush_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op = op; md_a = a; md_b = b; flush = 1'b1;
    #1;
    check("flush_stall", 32'(stall), 32'd0);
    tick();
    md_op = 4'd0; flush = 1'b0;
    #1;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_hi", hi, m_hi);
    check("flush_lo", lo, m_lo);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] ra, rb;

    reset = 1'b0; md_op = 4'd0; md_a = '0; md_b = '0; flush = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    md_op = 4'd7;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_rd", rd_data, 32'd0);
    reset = 1'b1;
    tick();

    // Directed arithmetic cases
    start_op(4'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    check("mult_lo_const", lo, 32'hFFFF_FFFA);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    start_op(4'd2, 32'hFFFF_FFFE, 32'h0000_0003);
    check("multu_hi_const", hi, 32'h0000_0002);
    start_op(4'd3, 32'hFFFF_FFF9, 32'h0000_0002);
    check("div_lo_const", lo, 32'hFFFF_FFFD);
    check("div_hi_const", hi, 32'hFFFF_FFFF);
    start_op(4'd4, 32'h0000_0007, 32'h0000_0000);
    check("divu0_lo_const", lo, 32'hFFFF_FFFF);
    check("divu0_hi_const", hi, 32'h0000_0007);
    start_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divovf_lo_const", lo, 32'h8000_0000);
    check("divovf_hi_const", hi, 32'h0000_0000);
    start_op(4'd3, 32'hFFFF_FFF0, 32'h0000_0000);
    start_op(4'd3, 32'h0000_0007, 32'hFFFF_FFFE);

    // Flush suppresses starts and moves
    flush_start(4'd1, 32'h0000_0005, 32'h0000_0007);
    flush_start(4'd3, 32'h0000_0064, 32'h0000_0003);
    mt_op(4'd5, 32'hDEAD_BEEF, 1'b1);

    // Move to LO then read on the next cycle
    mt_op(4'd6, 32'h1234_5678, 1'b0);
    check("mtlo_const", rd_data, 32'h1234_5678);

    // Randomized mix; consecutive starts are back to back
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(1, 6));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (op <= 4'd4) start_op(op, ra, rb);
      else mt_op(op, ra, ($urandom_range(0, 3) == 0));
    end

`ifdef MDU_MADD_EN
    mt_op(4'd5, 32'h0000_0000, 1'b0);
    mt_op(4'd6, 32'hFFFF_FFFF, 1'b0);
    start_op(4'd10, 32'h0000_0001, 32'h0000_0001);
    check("maddu_hi_const", hi, 32'h0000_0001);
    check("maddu_lo_const", lo, 32'h0000_0000);
    for (int i = 0; i < 4; i++) begin
      start_op(4'($urandom_range(9, 10)), $urandom, $urandom);
    end
`else
    mt_op(4'd5, 32'h0BAD_F00D, 1'b0);
    for (int i = 9; i <= 10; i++) begin
      md_op = 4'(i); md_a = $urandom; md_b = $urandom; flush = 1'b0;
      #1;
      check("nomadd_stall", 32'(stall), 32'd0);
      check("nomadd_rd", rd_data, 32'd0);
      tick();
      md_op = 4'd0;
      #1;
      check("nomadd_busy", 32'(busy), 32'd0);
      check("nomadd_hi", hi, m_hi);
      check("nomadd_lo", lo, m_lo);
    end
`endif

    // Reset in the middle of a divide
    mt_op(4'd5, 32'hA5A5_A5A5, 1'b0);
    md_op = 4'd3; md_a = 32'd100; md_b = 32'd7; flush = 1'b0;
    #1;
    tick();
    md_op = 4'd0;
    tick();
    tick();
    md_op = 4'd7;
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    m_hi = '0; m_lo = '0;
    tick();
    reset = 1'b1;
    tick();
    start_op(4'd1, $urandom, $urandom);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
